// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with run/stop control, line interrupt and registered outputs.
// Optional frame counter built when VGA_TIMING_FRAMECNT_EN is defined; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
    parameter int H_SYNC         = 120,
    parameter int H_BP           = 64,
    parameter int H_ACTIVE       = 800,
    parameter int H_FP           = 56,
    parameter int V_SYNC         = 6,
    parameter int V_BP           = 23,
    parameter int V_ACTIVE       = 600,
    parameter int V_FP           = 37,
    parameter int HS_ACTIVE_HIGH = 0,
    parameter int VS_ACTIVE_HIGH = 0,
    parameter int COORD_W        = 11
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pix_en,
    input  logic                      run,
    input  logic signed [COORD_W-1:0] line_match,
    output logic                      busy,
    output logic                      hs,
    output logic                      vs,
    output logic                      de,
    output logic                      sof,
    output logic                      eof,
    output logic                      sol,
    output logic                      eol,
    output logic signed [COORD_W-1:0] spot_x,
    output logic signed [COORD_W-1:0] spot_y,
    output logic                      line_irq,
    output logic [15:0]               frame_cnt
);

    localparam int H_TOT   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;
    localparam int CX_W    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int CY_W    = (V_TOT > 1) ? $clog2(V_TOT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic HS_ON = (HS_ACTIVE_HIGH != 0);
    localparam logic VS_ON = (VS_ACTIVE_HIGH != 0);

    logic [1:0]      state_reg, state_next;
    logic [CX_W-1:0] cx_reg, cx_next;
    logic [CY_W-1:0] cy_reg, cy_next;

    logic                      busy_reg, hs_reg, vs_reg, de_reg;
    logic                      sof_reg, eof_reg, sol_reg, eol_reg, irq_reg;
    logic signed [COORD_W-1:0] spot_x_reg, spot_y_reg;

    logic                      hs_next, vs_next, de_next;
    logic                      sof_next, eof_next, sol_next, eol_next, irq_next;
    logic signed [COORD_W-1:0] spot_x_next, spot_y_next;
    logic                      cx_last, cy_last, go_idle, load;
    int                        cx_i, cy_i;

    // Decode of the current position; loaded into the output registers on a tick.
    always_comb begin
        cx_i        = int'(cx_reg);
        cy_i        = int'(cy_reg);
        cx_last     = (cx_i == H_TOT - 1);
        cy_last     = (cy_i == V_TOT - 1);
        hs_next     = (cx_i < H_SYNC) ? HS_ON : ~HS_ON;
        vs_next     = (cy_i < V_SYNC) ? VS_ON : ~VS_ON;
        de_next     = (cx_i >= H_START) && (cx_i < H_END) && (cy_i >= V_START) && (cy_i < V_END);
        spot_x_next = de_next ? COORD_W'(cx_i - H_START) : '1;
        spot_y_next = de_next ? COORD_W'(cy_i - V_START) : '1;
        sol_next    = de_next && (cx_i == H_START);
        eol_next    = de_next && (cx_i == H_END - 1);
        sof_next    = sol_next && (cy_i == V_START);
        eof_next    = eol_next && (cy_i == V_END - 1);
        // A negative line_match never equals an active row index.
        irq_next    = eol_next && !line_match[COORD_W-1] && (spot_y_next == line_match);
        cx_next     = cx_last ? '0 : cx_reg + CX_W'(1);
        cy_next     = cy_reg;
        if (cx_last) begin
            cy_next = cy_last ? '0 : cy_reg + CY_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = run ? RUN : IDLE;
            RUN:     state_next = run ? RUN : DRAIN;
            DRAIN: begin
                if (run) begin
                    state_next = RUN;
                end else if (cx_last && cy_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        go_idle = (state_reg == DRAIN) && (state_next == IDLE);
        load    = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            hs_reg     <= ~HS_ON;
            vs_reg     <= ~VS_ON;
            de_reg     <= 1'b0;
            sof_reg    <= 1'b0;
            eof_reg    <= 1'b0;
            sol_reg    <= 1'b0;
            eol_reg    <= 1'b0;
            irq_reg    <= 1'b0;
            spot_x_reg <= '1;
            spot_y_reg <= '1;
        end else if (pix_en) begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            if (go_idle) begin
                cx_reg     <= '0;
                cy_reg     <= '0;
                hs_reg     <= ~HS_ON;
                vs_reg     <= ~VS_ON;
                de_reg     <= 1'b0;
                sof_reg    <= 1'b0;
                eof_reg    <= 1'b0;
                sol_reg    <= 1'b0;
                eol_reg    <= 1'b0;
                irq_reg    <= 1'b0;
                spot_x_reg <= '1;
                spot_y_reg <= '1;
            end else if (load) begin
                cx_reg     <= cx_next;
                cy_reg     <= cy_next;
                hs_reg     <= hs_next;
                vs_reg     <= vs_next;
                de_reg     <= de_next;
                sof_reg    <= sof_next;
                eof_reg    <= eof_next;
                sol_reg    <= sol_next;
                eol_reg    <= eol_next;
                irq_reg    <= irq_next;
                spot_x_reg <= spot_x_next;
                spot_y_reg <= spot_y_next;
            end
        end
    end

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] frame_cnt_reg;

    // Counts on the tick that loads eof, so it steps together with the eof pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_reg <= '0;
        end else if (pix_en && load && eof_next) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`else
    assign frame_cnt = '0;
`endif

    assign busy     = busy_reg;
    assign hs       = hs_reg;
    assign vs       = vs_reg;
    assign de       = de_reg;
    assign sof      = sof_reg;
    assign eof      = eof_reg;
    assign sol      = sol_reg;
    assign eol      = eol_reg;
    assign line_irq = irq_reg;
    assign spot_x   = spot_x_reg;
    assign spot_y   = spot_y_reg;

endmodule
